// File: rtl/button_events_pkg.sv
// Shared constants, event word layout and helpers for the push-button event source.
package button_events_pkg;

    localparam int NUM_KEYS = 4;
    localparam int KEY_W    = 2;
    localparam int EVT_W    = 4;

    // Button index of each board switch
    localparam logic [KEY_W-1:0] KEY_WRITE = 2'd0;  // S1
    localparam logic [KEY_W-1:0] KEY_NEXT  = 2'd1;  // S2
    localparam logic [KEY_W-1:0] KEY_VALUE = 2'd2;  // S3
    localparam logic [KEY_W-1:0] KEY_LATCH = 2'd3;  // S4

    // Event word: {repeat, press, key[1:0]}
    typedef struct packed {
        logic             rpt;
        logic             press;
        logic [KEY_W-1:0] key;
    } evt_t;

    // Index of the lowest set bit; KEY_WRITE when nothing is set
    function automatic logic [KEY_W-1:0] first_one(input logic [NUM_KEYS-1:0] v);
        first_one = KEY_WRITE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) first_one = KEY_W'(i);
        end
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One switch: two-flop synchroniser, stability counter and debounced level.
// chg_o is high in the cycle whose clock edge flips held_o.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n_i,
    output logic held_o,
    output logic chg_o
);

    logic                sync1_q, sync2_q;
    logic                held_q, held_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                s;

    // Synchronised level, active-high
    assign s = ~sync2_q;

    // Synchroniser; reset to the released (high) pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles the input disagrees with the debounced level
    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        chg_o  = 1'b0;
        if (s == held_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
            held_d = ~held_q;
            cnt_d  = '0;
            chg_o  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

    assign held_o = held_q;

endmodule

// File: rtl/button_events.sv
// Debounced press/release event source for the four active-low board switches.
// Per-button debouncers raise pending events; a fixed-priority arbiter pushes
// one per cycle into a show-ahead FIFO drained over valid/ready.
// Optional auto-repeat of the lowest held button: define BUTTON_EVENTS_REPEAT_EN.
module button_events
    import button_events_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 20,
    parameter int LOG2_DEPTH      = 2,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] buttons_n,
    output logic [NUM_KEYS-1:0] held,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                evt_repeat,
    output logic                evt_drop
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    // Elaboration-time parameter sanity
    if (DEBOUNCE_CYCLES < 8) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 8");
    end
    if ((64'd1 << CNT_BITS) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $error("CNT_BITS too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [NUM_KEYS-1:0] chg;
    logic [NUM_KEYS-1:0] rep_fire;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_n_i(buttons_n[i]),
            .held_o (held[i]),
            .chg_o  (chg[i])
        );
    end

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [NUM_KEYS-1:0][TMR_W-1:0] tmr_q;
    logic [NUM_KEYS-1:0]            first_q;
    logic [NUM_KEYS-1:0]            tmr_hit;
    logic [KEY_W-1:0]               rep_sel;

    assign rep_sel = first_one(held);

    // Timer expiry; the first interval after a press is the longer delay.
    // A release strobe on the same edge wins over a repeat.
    always_comb begin
        tmr_hit  = '0;
        rep_fire = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            tmr_hit[i]  = int'(tmr_q[i]) == ((first_q[i] ? REPEAT_DELAY : REPEAT_RATE) - 1);
            rep_fire[i] = held[i] && tmr_hit[i] && (rep_sel == KEY_W'(i)) && !chg[i];
        end
    end

    // Per-button repeat timers run while the button is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            first_q <= '1;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (!held[i]) begin
                    tmr_q[i]   <= '0;
                    first_q[i] <= 1'b1;
                end else if (tmr_hit[i]) begin
                    tmr_q[i]   <= '0;
                    first_q[i] <= 1'b0;
                end else begin
                    tmr_q[i] <= tmr_q[i] + 1'b1;
                end
            end
        end
    end
`else
    // No repeat source: every queued event carries rpt=0, so evt_repeat is constant 0
    assign rep_fire = '0;
`endif

    // ---------------- pending events and arbiter ----------------
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [NUM_KEYS-1:0] pend_press_q, pend_press_d;
    logic [NUM_KEYS-1:0] pend_rpt_q, pend_rpt_d;
    logic                push;
    logic [KEY_W-1:0]    push_idx;
    evt_t                push_evt;

    // Push the lowest pending bit; new strobes land after the clear
    always_comb begin
        pend_d       = pend_q;
        pend_press_d = pend_press_q;
        pend_rpt_d   = pend_rpt_q;
        push         = |pend_q;
        push_idx     = first_one(pend_q);
        push_evt     = '{rpt: pend_rpt_q[push_idx], press: pend_press_q[push_idx], key: push_idx};
        if (push) pend_d[push_idx] = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (chg[i]) begin
                pend_d[i]       = 1'b1;
                pend_press_d[i] = ~held[i];
                pend_rpt_d[i]   = 1'b0;
            end else if (rep_fire[i]) begin
                pend_d[i]       = 1'b1;
                pend_press_d[i] = 1'b1;
                pend_rpt_d[i]   = 1'b1;
            end
        end
    end

    // Pending event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_press_q <= '0;
            pend_rpt_q   <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_press_q <= pend_press_d;
            pend_rpt_q   <= pend_rpt_d;
        end
    end

    // ---------------- event FIFO ----------------
    evt_t                mem_q [DEPTH];
    logic [LOG2_DEPTH:0] wr_q, rd_q;
    logic                full, empty, pop, wr_en, drop_q;
    evt_t                head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[LOG2_DEPTH] != rd_q[LOG2_DEPTH]) &&
                   (wr_q[LOG2_DEPTH-1:0] == rd_q[LOG2_DEPTH-1:0]);
    assign pop   = !empty && evt_ready;
    // A pop in the same cycle frees the slot the push lands in
    assign wr_en = push && (!full || pop);
    assign head  = mem_q[rd_q[LOG2_DEPTH-1:0]];

    // FIFO storage, pointers and registered drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[LOG2_DEPTH-1:0]] <= push_evt;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            drop_q <= push && full && !pop;
        end
    end

    // Head fields read as zero while the FIFO is empty
    assign evt_valid  = !empty;
    assign evt_key    = evt_valid ? head.key   : '0;
    assign evt_press  = evt_valid ? head.press : 1'b0;
    assign evt_repeat = evt_valid ? head.rpt   : 1'b0;
    assign evt_drop   = drop_q;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events with DEBOUNCE_CYCLES=8.
// A behavioural model (pin history, stable-run rule, pending set, bounded
// event queue) is compared against the DUT on every falling edge; directed
// scenarios add literal expectations on top.
module tb_button_events;

    localparam int DC    = 8;
    localparam int DEPTH = 4;
    localparam int RDLY  = 32;
    localparam int RRATE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] buttons_n = 4'hF;
    logic       evt_ready = 1'b0;
    logic [3:0] held;
    logic       evt_valid, evt_press, evt_repeat, evt_drop;
    logic [1:0] evt_key;

    int n_checks = 0;
    int n_err    = 0;
    int n_drop   = 0;

    always #5 clk = ~clk;

    button_events #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_BITS       (4),
        .LOG2_DEPTH     (2),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_RATE    (RRATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons_n (buttons_n),
        .held      (held),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_press (evt_press),
        .evt_repeat(evt_repeat),
        .evt_drop  (evt_drop)
    );

    // ---------------- behavioural model ----------------
    logic [3:0] m_ph1 = 4'hF, m_ph2 = 4'hF;  // pin seen one / two edges ago
    logic [3:0] m_held = '0;
    logic [3:0] m_pend = '0, m_pend_press = '0, m_pend_rpt = '0;
    logic       m_drop = 1'b0;
    int         m_run  [4];
    int         m_hcyc [4];
    logic [3:0] mq [$];  // {rpt, press, key}

    task automatic model_reset();
        m_ph1 = 4'hF; m_ph2 = 4'hF; m_held = '0; m_pend = '0;
        m_pend_press = '0; m_pend_rpt = '0; m_drop = 1'b0; mq.delete();
        for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hcyc[i] = 0; end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [3:0] held_pre;
            logic [3:0] toggled;
            int         lo_held;
            held_pre = m_held;
            toggled  = '0;
            // consumer side
            if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
            // one push of the lowest pending button
            m_drop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i]) begin
                    if (mq.size() < DEPTH) mq.push_back({m_pend_rpt[i], m_pend_press[i], 2'(i)});
                    else m_drop = 1'b1;
                    m_pend[i] = 1'b0;
                    break;
                end
            end
            // level accepted after DC consecutive disagreeing cycles
            for (int i = 0; i < 4; i++) begin
                if (~m_ph2[i] != held_pre[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_run[i] = 0;
                        m_held[i] = ~held_pre[i];
                        toggled[i] = 1'b1;
                        m_pend[i] = 1'b1; m_pend_press[i] = m_held[i]; m_pend_rpt[i] = 1'b0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`ifdef BUTTON_EVENTS_REPEAT_EN
            // repeats at DELAY, DELAY+RATE, ... cycles after the press, lowest held key only
            lo_held = -1;
            for (int i = 3; i >= 0; i--) if (held_pre[i]) lo_held = i;
            for (int i = 0; i < 4; i++) begin
                if (held_pre[i]) begin
                    m_hcyc[i]++;
                    if (i == lo_held && !toggled[i] &&
                        (m_hcyc[i] == RDLY || (m_hcyc[i] > RDLY && (m_hcyc[i] - RDLY) % RRATE == 0))) begin
                        m_pend[i] = 1'b1; m_pend_press[i] = 1'b1; m_pend_rpt[i] = 1'b1;
                    end
                end else begin
                    m_hcyc[i] = 0;
                end
            end
`else
            lo_held = 0;
`endif
            m_ph2 = m_ph1;
            m_ph1 = buttons_n;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic       ev;
        logic [3:0] eh;
        ev = (mq.size() > 0);
        eh = ev ? mq[0] : 4'h0;
        n_checks++;
        if (held !== m_held || evt_valid !== ev || evt_drop !== m_drop ||
            {evt_repeat, evt_press, evt_key} !== eh) begin
            n_err++;
            $display("FAIL model t=%0t held=%b exp %b valid=%b exp %b drop=%b exp %b head=%h exp %h",
                     $time, held, m_held, evt_valid, ev, evt_drop, m_drop,
                     {evt_repeat, evt_press, evt_key}, eh);
        end
        if (evt_drop === 1'b1) n_drop++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a head event, check it literally, then pop it
    task automatic pop_expect(input string name, input logic [1:0] key, input logic press, input logic rpt);
        int w;
        w = 0;
        while (evt_valid !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        chk({name, "_valid"}, 32'(evt_valid), 32'd1);
        chk({name, "_evt"}, {29'd0, evt_repeat, evt_press, evt_key}, {29'd0, rpt, press, key});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int d0;
        int np, nr, nrel;

        // 1: reset with random pins
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            buttons_n = 4'($urandom_range(0, 15));
            chk("rst_held", 32'(held), 32'd0);
            chk("rst_valid", 32'(evt_valid), 32'd0);
            chk("rst_drop", 32'(evt_drop), 32'd0);
        end
        buttons_n = 4'hF;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);

        // 2: S3 press then release
        buttons_n[2] = 1'b0;
        cycles(9);
        chk("s3_held_before", 32'(held), 32'h0);
        cycles(1);
        chk("s3_held_after", 32'(held), 32'h4);
        cycles(1);
        chk("s3_valid", 32'(evt_valid), 32'd1);
        pop_expect("s3_press", 2'd2, 1'b1, 1'b0);
        buttons_n[2] = 1'b1;
        cycles(12);
        pop_expect("s3_release", 2'd2, 1'b0, 1'b0);
        chk("s3_empty", 32'(evt_valid), 32'd0);

        // 3: bounce on S1 never qualifies
        for (int i = 0; i < 10; i++) begin
            buttons_n[0] = ~buttons_n[0];
            cycles(3);
        end
        buttons_n[0] = 1'b1;
        cycles(20);
        chk("bounce_held", 32'(held), 32'h0);
        chk("bounce_valid", 32'(evt_valid), 32'd0);

        // 4: simultaneous S2+S4, delivered in index order
        buttons_n = 4'b0101;
        cycles(14);
        pop_expect("dual_k1", 2'd1, 1'b1, 1'b0);
        pop_expect("dual_k3", 2'd3, 1'b1, 1'b0);
        buttons_n = 4'hF;
        cycles(14);
        pop_expect("dual_r1", 2'd1, 1'b0, 1'b0);
        pop_expect("dual_r3", 2'd3, 1'b0, 1'b0);

        // 5: overflow, fifth event dropped
        d0 = n_drop;
        buttons_n = 4'h0;
        cycles(14);
        buttons_n = 4'b0001;
        cycles(14);
        chk("ovf_drop_count", 32'(n_drop - d0), 32'd1);
        chk("ovf_held", 32'(held), 32'hE);
        pop_expect("ovf_0", 2'd0, 1'b1, 1'b0);
        pop_expect("ovf_1", 2'd1, 1'b1, 1'b0);
        pop_expect("ovf_2", 2'd2, 1'b1, 1'b0);
        pop_expect("ovf_3", 2'd3, 1'b1, 1'b0);
        chk("ovf_empty", 32'(evt_valid), 32'd0);
        buttons_n = 4'hF;
        cycles(14);
        pop_expect("ovf_r1", 2'd1, 1'b0, 1'b0);
        pop_expect("ovf_r2", 2'd2, 1'b0, 1'b0);
        pop_expect("ovf_r3", 2'd3, 1'b0, 1'b0);

`ifdef BUTTON_EVENTS_REPEAT_EN
        // 6: auto-repeat on S1 with an always-ready consumer
        np = 0; nr = 0; nrel = 0;
        evt_ready = 1'b1;
        buttons_n[0] = 1'b0;
        for (int w = 0; w < 40 && held[0] !== 1'b1; w++) @(negedge clk);
        chk("rep_held", 32'(held), 32'h1);
        for (int c = 0; c < 150; c++) begin
            if (c == 100) buttons_n[0] = 1'b1;
            @(negedge clk);
            if (evt_valid === 1'b1) begin
                if (evt_repeat) nr++;
                else if (evt_press) np++;
                else nrel++;
            end
        end
        evt_ready = 1'b0;
        chk("rep_press", 32'(np), 32'd1);
        chk("rep_repeats", 32'(nr), 32'd5);
        chk("rep_release", 32'(nrel), 32'd1);
`else
        np = 0; nr = 0; nrel = 0;
`endif

        // reset mid-operation drops the queued event without a drop pulse
        buttons_n = 4'b1011;
        cycles(14);
        chk("mid_valid_pre", 32'(evt_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(evt_valid), 32'd0);
        chk("mid_held", 32'(held), 32'd0);
        chk("mid_drop", 32'(evt_drop), 32'd0);
        buttons_n = 4'hF;
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        chk("post_valid", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
